// File: rtl/conv_scan_ctrl.sv
// Frame sequencer for the 3x3 convolution core: column-of-three source reads, locked core enable
// and window write capture. Define CONV_BORDER_FILL_EN to zero-fill the frame border after a scan.
module conv_scan_ctrl #(
  parameter int unsigned IMG_W  = 352,
  parameter int unsigned IMG_H  = 288,
  parameter int unsigned ADDR_W = 17,
  parameter int unsigned RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              hold,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              conv_en,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
`ifdef CONV_BORDER_FILL_EN
  output logic              border_sel,
`endif
  output logic              busy,
  output logic              done
);

  localparam int unsigned XW = $clog2(IMG_W);
  localparam int unsigned YW = $clog2(IMG_H);
  localparam logic [XW-1:0]     XLast     = XW'(IMG_W - 1);
  localparam logic [YW-1:0]     YLast     = YW'(IMG_H - 2);
  localparam logic [ADDR_W-1:0] Stride    = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] CentreOff = ADDR_W'(IMG_W + 1);

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StPause,
    StDrain,
    StDone
`ifdef CONV_BORDER_FILL_EN
    , StBorder
`endif
  } state_e;

  state_e            state_q;
  logic [XW-1:0]     x_q;
  logic [YW-1:0]     y_q;
  logic [1:0]        ph_q;
  logic [ADDR_W-1:0] col_q;    // address of row y-1 at column x; steps by one per group
  logic [1:0]        drain_q;

  // Tag pipe travelling with rd_en; its last stage is the core enable.
  logic [RD_LAT-1:0] pv_q;
  logic [1:0]        pph_q [RD_LAT];
  logic [XW-1:0]     px_q  [RD_LAT];
  logic [ADDR_W-1:0] pa_q  [RD_LAT];

  logic              core_wr;
  logic [ADDR_W-1:0] core_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv_q <= '0;
      for (int i = 0; i < RD_LAT; i++) begin
        pph_q[i] <= '0;
        px_q[i]  <= '0;
        pa_q[i]  <= '0;
      end
    end else begin
      pv_q[0]  <= rd_en;
      pph_q[0] <= ph_q;
      px_q[0]  <= x_q;
      pa_q[0]  <= rd_addr;
      for (int i = 1; i < RD_LAT; i++) begin
        pv_q[i]  <= pv_q[i-1];
        pph_q[i] <= pph_q[i-1];
        px_q[i]  <= px_q[i-1];
        pa_q[i]  <= pa_q[i-1];
      end
    end
  end

  assign conv_en = pv_q[RD_LAT-1];

  // The ph=2 read sits at (y+1, x); the finished window is centred at (y, x-1).
  always_comb begin
    core_wr   = pv_q[RD_LAT-1] && (pph_q[RD_LAT-1] == 2'd2) && (px_q[RD_LAT-1] >= XW'(2));
    core_addr = pa_q[RD_LAT-1] - CentreOff;
  end

`ifdef CONV_BORDER_FILL_EN
  localparam int unsigned CW = $clog2(IMG_W + IMG_H);
  localparam logic [ADDR_W-1:0] BotRow = ADDR_W'((IMG_H - 1) * IMG_W);

  // Border segments: top row, bottom row, left column, right column.
  logic [1:0]        bseg_q;
  logic [CW-1:0]     bcnt_q;
  logic [CW-1:0]     b_last;
  logic [ADDR_W-1:0] b_step;
  logic [ADDR_W-1:0] b_next;

  always_comb begin
    b_last = bseg_q[1] ? CW'(IMG_H - 3) : CW'(IMG_W - 1);
    b_step = bseg_q[1] ? Stride : ADDR_W'(1);
    unique case (bseg_q)
      2'd0:    b_next = BotRow;
      2'd1:    b_next = Stride;
      default: b_next = Stride + Stride - ADDR_W'(1);
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= YW'(1);
      ph_q       <= '0;
      col_q      <= '0;
      drain_q    <= '0;
      rd_en      <= 1'b0;
      rd_addr    <= '0;
      wr_en      <= 1'b0;
      wr_addr    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
`ifdef CONV_BORDER_FILL_EN
      border_sel <= 1'b0;
      bseg_q     <= '0;
      bcnt_q     <= '0;
`endif
    end else begin
      wr_en   <= core_wr;
      wr_addr <= core_addr;
      done    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy    <= 1'b1;
            x_q     <= '0;
            y_q     <= YW'(1);
            ph_q    <= '0;
            col_q   <= '0;
            rd_addr <= '0;
            if (hold) begin
              state_q <= StPause;
            end else begin
              state_q <= StFetch;
              rd_en   <= 1'b1;
            end
          end
        end
        StFetch: begin
          if (ph_q != 2'd2) begin
            ph_q    <= ph_q + 2'd1;
            rd_addr <= rd_addr + Stride;
          end else if (x_q == XLast && y_q == YLast) begin
            rd_en   <= 1'b0;
            drain_q <= '0;
            state_q <= StDrain;
          end else begin
            ph_q    <= '0;
            col_q   <= col_q + ADDR_W'(1);
            rd_addr <= col_q + ADDR_W'(1);
            if (x_q == XLast) begin
              x_q <= '0;
              y_q <= y_q + YW'(1);
            end else begin
              x_q <= x_q + XW'(1);
            end
            // Group boundary: the only point where hold is honoured.
            if (hold) begin
              rd_en   <= 1'b0;
              state_q <= StPause;
            end
          end
        end
        StPause: begin
          if (!hold) begin
            rd_en   <= 1'b1;
            rd_addr <= col_q;
            state_q <= StFetch;
          end
        end
        StDrain: begin
          if (drain_q == 2'(RD_LAT)) begin
`ifdef CONV_BORDER_FILL_EN
            state_q    <= StBorder;
            wr_en      <= 1'b1;
            wr_addr    <= '0;
            border_sel <= 1'b1;
            bseg_q     <= '0;
            bcnt_q     <= '0;
`else
            done    <= 1'b1;
            state_q <= StDone;
`endif
          end else begin
            drain_q <= drain_q + 2'd1;
          end
        end
`ifdef CONV_BORDER_FILL_EN
        StBorder: begin
          if (bcnt_q == b_last) begin
            if (bseg_q == 2'd3) begin
              wr_en      <= 1'b0;
              border_sel <= 1'b0;
              done       <= 1'b1;
              state_q    <= StDone;
            end else begin
              bseg_q  <= bseg_q + 2'd1;
              bcnt_q  <= '0;
              wr_en   <= 1'b1;
              wr_addr <= b_next;
            end
          end else begin
            bcnt_q  <= bcnt_q + CW'(1);
            wr_en   <= 1'b1;
            wr_addr <= wr_addr + b_step;
          end
        end
`endif
        StDone: begin
          busy    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_scan_ctrl.sv
// Bench for conv_scan_ctrl: two 4x4 instances (RD_LAT 1 and 3) on shared stimulus, checked
// against queued expected read/write addresses plus a table of frame scenarios.
module tb_conv_scan_ctrl;
  localparam int W  = 4;
  localparam int H  = 4;
  localparam int AW = 8;
  localparam int NRD = 3 * W * (H - 2);
`ifdef CONV_BORDER_FILL_EN
  localparam int NWR = (W - 2) * (H - 2) + 2 * W + 2 * (H - 2);
`else
  localparam int NWR = (W - 2) * (H - 2);
`endif

  logic clk = 1'b0;
  logic rst_n, start, hold;
  always #5 clk = ~clk;

  logic a_rd_en, a_conv_en, a_wr_en, a_busy, a_done, a_bsel;
  logic b_rd_en, b_conv_en, b_wr_en, b_busy, b_done, b_bsel;
  logic [AW-1:0] a_rd_addr, a_wr_addr, b_rd_addr, b_wr_addr;

  conv_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .rd_en(a_rd_en), .rd_addr(a_rd_addr), .conv_en(a_conv_en),
    .wr_en(a_wr_en), .wr_addr(a_wr_addr),
`ifdef CONV_BORDER_FILL_EN
    .border_sel(a_bsel),
`endif
    .busy(a_busy), .done(a_done)
  );

  conv_scan_ctrl #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW), .RD_LAT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start), .hold(hold),
    .rd_en(b_rd_en), .rd_addr(b_rd_addr), .conv_en(b_conv_en),
    .wr_en(b_wr_en), .wr_addr(b_wr_addr),
`ifdef CONV_BORDER_FILL_EN
    .border_sel(b_bsel),
`endif
    .busy(b_busy), .done(b_done)
  );

`ifndef CONV_BORDER_FILL_EN
  assign a_bsel = 1'b0;
  assign b_bsel = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int qr_a[$], qr_b[$], qw_a[$], qw_b[$];
  int n_rd[2], n_wr[2], n_done[2];
  logic [2:0] hist[2];
  logic pce[2];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Expected write entries encode border_sel above the address bits.
  task automatic mon(input int d, input int lat, input logic re, input logic [AW-1:0] ra,
                     input logic ce, input logic we, input logic [AW-1:0] wa, input logic bs,
                     input logic bz, input logic dn);
    logic ece;
    int act_w;
    if (!rst_n) begin
      hist[d] = '0;
      pce[d]  = 1'b0;
      return;
    end
    ece = hist[d][lat-1];
    if (ce || ece) chk($sformatf("conv_en_lag_d%0d", d), int'(ce), int'(ece));
    hist[d] = {hist[d][1:0], re};
    if (re || we || ce) chk($sformatf("busy_active_d%0d", d), int'(bz), 1);
    if (re) begin
      n_rd[d]++;
      if (d == 0) begin
        if (qr_a.size() == 0) chk("rd_extra_d0", 1, 0);
        else chk("rd_addr_d0", int'(ra), qr_a.pop_front());
      end else begin
        if (qr_b.size() == 0) chk("rd_extra_d1", 1, 0);
        else chk("rd_addr_d1", int'(ra), qr_b.pop_front());
      end
    end
    if (we) begin
      n_wr[d]++;
      act_w = int'({bs, wa});
      if (!bs) chk($sformatf("wr_after_conv_d%0d", d), int'(pce[d]), 1);
      if (d == 0) begin
        if (qw_a.size() == 0) chk("wr_extra_d0", 1, 0);
        else chk("wr_addr_d0", act_w, qw_a.pop_front());
      end else begin
        if (qw_b.size() == 0) chk("wr_extra_d1", 1, 0);
        else chk("wr_addr_d1", act_w, qw_b.pop_front());
      end
    end
    if (dn) begin
      n_done[d]++;
      chk($sformatf("done_after_writes_d%0d", d), (d == 0) ? qw_a.size() : qw_b.size(), 0);
    end
    pce[d] = ce;
  endtask

  task automatic tick();
    @(negedge clk);
    mon(0, 1, a_rd_en, a_rd_addr, a_conv_en, a_wr_en, a_wr_addr, a_bsel, a_busy, a_done);
    mon(1, 3, b_rd_en, b_rd_addr, b_conv_en, b_wr_en, b_wr_addr, b_bsel, b_busy, b_done);
  endtask

  task automatic push_w(input int v);
    qw_a.push_back(v);
    qw_b.push_back(v);
  endtask

  task automatic push_frame();
    for (int y = 1; y <= H - 2; y++)
      for (int x = 0; x < W; x++)
        for (int p = 0; p < 3; p++) begin
          qr_a.push_back((y - 1 + p) * W + x);
          qr_b.push_back((y - 1 + p) * W + x);
        end
    for (int y = 1; y <= H - 2; y++)
      for (int x = 2; x < W; x++) push_w(y * W + x - 1);
`ifdef CONV_BORDER_FILL_EN
    for (int x = 0; x < W; x++) push_w(256 + x);
    for (int x = 0; x < W; x++) push_w(256 + (H - 1) * W + x);
    for (int r = 1; r <= H - 2; r++) push_w(256 + r * W);
    for (int r = 1; r <= H - 2; r++) push_w(256 + r * W + W - 1);
`endif
  endtask

  task automatic clear_stats();
    for (int d = 0; d < 2; d++) begin
      n_rd[d] = 0;
      n_wr[d] = 0;
      n_done[d] = 0;
    end
  endtask

  typedef struct {
    int hold_at;      // read index during which hold rises (-1: never)
    int hold_len;
    int restart_at;   // read index during which start is re-pulsed (-1: never)
    int exp_hold_reads;
    int exp_reads;
    int exp_writes;
    int exp_done;
  } vec_t;

  vec_t vecs[5];

  task automatic run_frame(input int idx, input vec_t v);
    int hold_cnt;
    int hold_reads;
    clear_stats();
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    chk($sformatf("v%0d_busy_after_start_a", idx), int'(a_busy), 1);
    chk($sformatf("v%0d_busy_after_start_b", idx), int'(b_busy), 1);
    hold_cnt = -1;
    hold_reads = 0;
    for (int c = 0; c < 300 && !(n_done[0] > 0 && n_done[1] > 0); c++) begin
      if (v.hold_at >= 0 && hold_cnt < 0 && a_rd_en && n_rd[0] == v.hold_at + 1) begin
        hold = 1'b1;
        hold_cnt = v.hold_len;
      end else if (hold_cnt > 0) begin
        hold_cnt--;
        if (hold_cnt == 0) hold = 1'b0;
      end
      start = (v.restart_at >= 0 && a_rd_en && n_rd[0] == v.restart_at + 1);
      tick();
      if (hold && a_rd_en) hold_reads++;
    end
    hold = 1'b0;
    start = 1'b0;
    if (!(n_done[0] > 0 && n_done[1] > 0)) chk($sformatf("v%0d_frame_timeout", idx), 0, 1);
    for (int c = 0; c < 4; c++) tick();
    chk($sformatf("v%0d_reads_a", idx), n_rd[0], v.exp_reads);
    chk($sformatf("v%0d_reads_b", idx), n_rd[1], v.exp_reads);
    chk($sformatf("v%0d_writes_a", idx), n_wr[0], v.exp_writes);
    chk($sformatf("v%0d_writes_b", idx), n_wr[1], v.exp_writes);
    chk($sformatf("v%0d_done_a", idx), n_done[0], v.exp_done);
    chk($sformatf("v%0d_done_b", idx), n_done[1], v.exp_done);
    chk($sformatf("v%0d_busy_end", idx), int'(a_busy) + int'(b_busy), 0);
    if (v.hold_at >= 0) chk($sformatf("v%0d_hold_reads", idx), hold_reads, v.exp_hold_reads);
    qr_a.delete(); qr_b.delete(); qw_a.delete(); qw_b.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_a_rd_en"}, int'(a_rd_en), 0);
    chk({tag, "_a_rd_addr"}, int'(a_rd_addr), 0);
    chk({tag, "_a_conv_en"}, int'(a_conv_en), 0);
    chk({tag, "_a_wr_en"}, int'(a_wr_en), 0);
    chk({tag, "_a_busy"}, int'(a_busy), 0);
    chk({tag, "_a_done"}, int'(a_done), 0);
    chk({tag, "_b_rd_en"}, int'(b_rd_en), 0);
    chk({tag, "_b_conv_en"}, int'(b_conv_en), 0);
    chk({tag, "_b_wr_en"}, int'(b_wr_en), 0);
    chk({tag, "_b_busy"}, int'(b_busy), 0);
    chk({tag, "_b_done"}, int'(b_done), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{hold_at: -1, hold_len: 0, restart_at: -1, exp_hold_reads: 0,
                exp_reads: NRD, exp_writes: NWR, exp_done: 1};
    vecs[1] = '{hold_at: 1, hold_len: 6, restart_at: -1, exp_hold_reads: 1,
                exp_reads: NRD, exp_writes: NWR, exp_done: 1};
    vecs[2] = '{hold_at: 13, hold_len: 3, restart_at: -1, exp_hold_reads: 1,
                exp_reads: NRD, exp_writes: NWR, exp_done: 1};
    vecs[3] = '{hold_at: -1, hold_len: 0, restart_at: 5, exp_hold_reads: 0,
                exp_reads: NRD, exp_writes: NWR, exp_done: 1};
    vecs[4] = '{hold_at: 22, hold_len: 4, restart_at: -1, exp_hold_reads: 1,
                exp_reads: NRD, exp_writes: NWR, exp_done: 1};

    rst_n = 1'b0;
    start = 1'b0;
    hold  = 1'b0;
    clear_stats();
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 5; i++) run_frame(i, vecs[i]);

    // Abort mid-frame: reset lands after the tenth read.
    clear_stats();
    push_frame();
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 0; c < 100 && n_rd[0] < 10; c++) tick();
    chk("abort_reached_read10", n_rd[0], 10);
    #2 rst_n = 1'b0;
    #1 chk_all_zero("abort");
    qr_a.delete(); qr_b.delete(); qw_a.delete(); qw_b.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    clear_stats();
    repeat (6) tick();
    chk("abort_no_done", n_done[0] + n_done[1], 0);
    chk("abort_idle_reads", n_rd[0] + n_rd[1], 0);
    run_frame(5, vecs[0]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_scan_ctrl.md
Name: conv_scan_ctrl

Overview:
- Frame-level sequencer for the 3x3 convolution core.
- Walks the source frame buffer in column-of-three order and issues read addresses and read enables.
- Drives the core's enable (LOCKED) so its internal mod-3 load phase never slips.
- Captures each completed window result as a write address and write enable for the destination buffer, with start/busy/done handshake to the frame-level control.

Parameters:
- IMG_W, 352, frame width in pixels (>=3).
- IMG_H, 288, frame height in lines (>=3).
- ADDR_W, 17, frame buffer address width; must satisfy 2^ADDR_W >= IMG_W*IMG_H.
- RD_LAT, 1, source memory read latency in cycles (1..3).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when idle.
- hold  in  1  pause request from downstream; honoured only at column-group boundaries.
- rd_en  out  1  source buffer read strobe.
- rd_addr  out  ADDR_W  source pixel address, row*IMG_W + col.
- conv_en  out  1  drives the core's LOCKED input; equals rd_en delayed RD_LAT cycles.
- wr_en  out  1  destination write strobe; core pixel_out is sampled this cycle.
- wr_addr  out  ADDR_W  destination address of the window centre.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse after the last write of a frame.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters y=1, x=0, ph=0, delay pipes cleared.
- FSM states:
  - IDLE: start=1 -> FETCH; busy<=1.
  - FETCH: issue one read per cycle. ph=0, 1, 2 read rows y-1, y, y+1 at column x. After ph=2: x increments; at x=IMG_W-1, x<=0 and y increments. After the group with y=IMG_H-2, x=IMG_W-1 -> DRAIN.
  - PAUSE: entered instead of starting a new group when hold=1 at ph=0. No rd_en while in PAUSE. Leaves to FETCH on the first cycle hold=0. A group, once started, always completes: three contiguous rd_en cycles, never split.
  - DRAIN: wait RD_LAT+1 cycles for the final conv_en and wr_en.
  - DONE: done=1 for one cycle, busy<=0 -> IDLE.
- start while busy is ignored. start and a final write in the same cycle: start is ignored.
- conv_en is a pure RD_LAT-stage shift of rd_en, so the core loads exactly in group order and keeps phase 0/1/2.
- Write capture: a tagged pipe carries (x, y, ph) alongside rd_en. wr_en fires the cycle after a conv_en with ph=2, only when x>=2. wr_addr = y*IMG_W + (x-1).
- The first two columns of each line load the window and never write. Writes per line = IMG_W-2. Writes per frame = (IMG_W-2)*(IMG_H-2). Reads per frame = 3*IMG_W*(IMG_H-2).
- Address arithmetic: incremental adds only, no multipliers. Row base registers advance by IMG_W per line; all arithmetic is unsigned ADDR_W wide and never wraps inside a legal frame.
- hold is sampled at ph=0 only. hold rising mid-group has no effect until the group ends.
- rst_n asserted mid-frame aborts immediately: all strobes 0, busy 0, no done pulse. The core has no reset, so the frame-level control must reset both together. Resetting this block alone is unsupported.

Optional Feature:
- Macro: CONV_BORDER_FILL_EN.
- Defined: after DRAIN, a BORDER state writes constant 0 to every destination pixel not produced by the core, one per cycle with wr_en=1 and a border_sel output=1 that muxes 0 onto the write data. Border pixels are rows 0 and IMG_H-1, columns 0 and IMG_W-1. Order: row 0 left to right, then row IMG_H-1, then column 0 rows 1..IMG_H-2, then column IMG_W-1 rows 1..IMG_H-2. That is 2*IMG_W + 2*(IMG_H-2) writes, then DONE.
- Undefined: no BORDER state and no border_sel port; border locations are untouched.

Test Plan:
- IMG_W=4, IMG_H=4, RD_LAT=1, single start, hold=0 -> 24 rd_en cycles, rd_addr sequence 0,4,8,1,5,9,...; 4 wr_en pulses with wr_addr 5,6,9,10; done pulses exactly once; busy high throughout.
- Same frame with hold=1 asserted during the second cycle of a group -> that group finishes all 3 reads, then PAUSE; no rd_en until hold=0; write addresses and counts unchanged.
- RD_LAT=3 -> conv_en trails rd_en by exactly 3 cycles; wr_en trails the third conv_en of each column (x>=2) by 1 cycle.
- start pulsed again while busy -> ignored; one done only; next start after done runs a full second frame.
- rst_n low at read 10 -> all outputs 0 asynchronously, busy=0, no done; start after release runs a clean frame from address 0.
- CONV_BORDER_FILL_EN defined, 4x4 -> after the 4 core writes, 12 border writes in order 0,1,2,3,12,13,14,15,4,8,7,11 with border_sel=1, then done.
